// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: receive-side checker for the 8-bit LFSR pattern generator.
// Synchronises to the incoming word stream, predicts each next word, declares
// lock after LOCK_COUNT correct predictions and counts errors while locked.
// Optional build macro LFSR_CHK_BITERR_EN: when defined, a locked mismatch adds
// the number of differing bits to err_count instead of 1.
//
// state   | meaning
// SEARCH  | waiting for a non-zero word to use as seed
// VERIFY  | seeded, counting consecutive correct predictions
// LOCKED  | flywheel prediction, mismatches counted as errors
module lfsr_seq_checker #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS      = 'hB8,
  parameter int              LOCK_COUNT = 4,
  parameter int              LOSS_COUNT = 3,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam int IW = $clog2(WIDTH + 1);
  localparam int SW = CNT_W + IW;

  logic [1:0]       state;
  logic [WIDTH-1:0] seed;
  logic [MW-1:0]    match_cnt;
  logic [LW-1:0]    miss_cnt;
  logic [WIDTH-1:0] pred;
  logic             hit;
  logic [IW-1:0]    inc;
  logic [CNT_W-1:0] base;
  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] err_next;

  function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  assign pred     = next_word(seed);
  assign hit      = (data_in == pred);
  assign expected = seed;

  // Error increment and saturating next value of err_count (clear applied first)
  always_comb begin
    inc = '0;
`ifdef LFSR_CHK_BITERR_EN
    for (int i = 0; i < WIDTH; i++) begin
      inc = inc + IW'(data_in[i] ^ pred[i]);
    end
`else
    inc = IW'(1);
`endif
    base     = clear_cnt ? '0 : err_count;
    sum      = {{IW{1'b0}}, base} + {{CNT_W{1'b0}}, inc};
    err_next = (|sum[SW-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
  end

  // Sequencer: search / verify / locked with error counting
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      seed      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      mismatch <= 1'b0;
      if (clear_cnt) err_count <= '0;
      if (valid_in) begin
        case (state)
          SEARCH: begin
            // An all-zero word is the LFSR lock-up state and can never seed.
            if (data_in != '0) begin
              seed      <= data_in;
              match_cnt <= '0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (hit) begin
              seed      <= data_in;
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else if (data_in != '0) begin
              seed      <= data_in;
              match_cnt <= '0;
            end else begin
              state     <= SEARCH;
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: once locked the prediction never reseeds from input.
            seed <= pred;
            if (hit) begin
              miss_cnt <= '0;
            end else begin
              mismatch  <= 1'b1;
              err_count <= err_next;
              miss_cnt  <= miss_cnt + 1'b1;
              if (miss_cnt == LW'(LOSS_COUNT - 1)) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Self-checking bench for lfsr_seq_checker with a behavioural reference model.
module tb_lfsr_seq_checker;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;
  localparam int MAXE = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             valid_in = 1'b0;
  logic             clear_cnt = 1'b0;
  logic             locked;
  logic             mismatch;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 = search, 1 = verify, 2 = locked
  int       m_mode;
  int       m_run;
  int       m_miss;
  int       m_err;
  bit       m_mis;
  bit       m_lock;
  bit [7:0] m_seed;

  lfsr_seq_checker #(.WIDTH(WIDTH), .TAPS(8'hB8), .LOCK_COUNT(LOCK_N),
                     .LOSS_COUNT(LOSS_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .clear_cnt(clear_cnt), .locked(locked), .mismatch(mismatch),
    .err_count(err_count), .expected(expected));

  always #5 clk = ~clk;

  // next LFSR word: doubled modulo 256 plus parity of the tapped bits
  function automatic bit [7:0] lfsr_next(input bit [7:0] s);
    int p;
    p = $countones(s & 8'hB8) % 2;
    return 8'(((int'(s) * 2) % 256) + p);
  endfunction

  task automatic model_update(input bit r, input bit v, input bit [7:0] d, input bit c);
    bit [7:0] p;
    int inc;
    if (r) begin
      m_mode = 0; m_run = 0; m_miss = 0; m_err = 0; m_mis = 0; m_lock = 0; m_seed = 0;
      return;
    end
    m_mis = 0;
    if (c) m_err = 0;
    if (!v) return;
    p = lfsr_next(m_seed);
    if (m_mode == 0) begin
      if (d != 0) begin m_seed = d; m_run = 0; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (d == p) begin
        m_seed = d; m_run++;
        if (m_run == LOCK_N) begin m_mode = 2; m_lock = 1; m_miss = 0; end
      end else if (d != 0) begin
        m_seed = d; m_run = 0;
      end else begin
        m_mode = 0; m_run = 0;
      end
    end else begin
      m_seed = p;
      if (d == p) m_miss = 0;
      else begin
        m_mis = 1;
`ifdef LFSR_CHK_BITERR_EN
        inc = $countones(d ^ p);
`else
        inc = 1;
`endif
        m_err = (m_err + inc > MAXE) ? MAXE : m_err + inc;
        m_miss++;
        if (m_miss == LOSS_N) begin m_mode = 0; m_lock = 0; m_run = 0; m_miss = 0; end
      end
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit [7:0] d, input bit c);
    @(negedge clk);
    rst = r; valid_in = v; data_in = d; clear_cnt = c;
    @(posedge clk);
    model_update(r, v, d, c);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 8'h00, 0);
    drive(1, 1, 8'h5A, 0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %0b want 0", mismatch); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_err got %0h want 0", err_count); end
    checks++; if (expected !== 8'h00) begin errors++; $display("FAIL reset_expected got %0h want 00", expected); end
    drive(0, 0, 8'h00, 0);
  endtask

  task automatic test_lock_acquire();
    bit [7:0] w [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, w[i], 0);
      checks++; if (locked !== (i >= 4)) begin errors++; $display("FAIL acquire_locked word %0h got %0b want %0b", w[i], locked, i >= 4); end
      checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL acquire_mismatch word %0h got %0b want 0", w[i], mismatch); end
      checks++; if (expected !== w[i]) begin errors++; $display("FAIL acquire_expected got %0h want %0h", expected, w[i]); end
      checks++; if (err_count !== '0) begin errors++; $display("FAIL acquire_err got %0h want 0", err_count); end
    end
  endtask

  task automatic test_single_error();
    bit [7:0] good;
    good = lfsr_next(m_seed);
    drive(0, 1, good, 0);
    drive(0, 1, lfsr_next(m_seed) ^ 8'h01, 0);
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL single_pulse got %0b want 1", mismatch); end
    checks++; if (err_count !== 4'd1) begin errors++; $display("FAIL single_err got %0h want 1", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got %0b want 1", locked); end
    drive(0, 1, lfsr_next(m_seed), 0);
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL single_pulse_end got %0b want 0", mismatch); end
    checks++; if (expected !== m_seed) begin errors++; $display("FAIL single_flywheel got %0h want %0h", expected, m_seed); end
  endtask

  task automatic test_loss_relock();
    bit [7:0] g;
    for (int i = 0; i < LOSS_N; i++) begin
      drive(0, 1, lfsr_next(m_seed) ^ 8'($urandom_range(1, 255)), 0);
      checks++; if (locked !== (i < LOSS_N - 1)) begin errors++; $display("FAIL loss_locked miss %0d got %0b want %0b", i, locked, i < LOSS_N - 1); end
      checks++; if (err_count !== 4'(m_err)) begin errors++; $display("FAIL loss_err got %0h want %0h", err_count, m_err); end
    end
    g = m_seed;
    for (int i = 0; i <= LOCK_N; i++) begin
      g = lfsr_next(g);
      drive(0, 1, g, 0);
      checks++; if (locked !== (i == LOCK_N)) begin errors++; $display("FAIL relock step %0d got %0b want %0b", i, locked, i == LOCK_N); end
    end
  endtask

  task automatic test_zero_words();
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'h00, 0);
      checks++; if (locked !== 1'b0 || expected !== 8'h00) begin errors++; $display("FAIL zero_words got locked=%0b expected=%0h want 0/00", locked, expected); end
    end
    drive(0, 1, 8'h01, 0);
    for (int i = 0; i < LOCK_N; i++) drive(0, 1, lfsr_next(m_seed), 0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL zero_then_lock got %0b want 1", locked); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, lfsr_next(m_seed) ^ 8'h10, 0);
      drive(0, 1, lfsr_next(m_seed) ^ 8'h03, 0);
      drive(0, 1, lfsr_next(m_seed), 0);
    end
    checks++; if (err_count !== 4'(MAXE)) begin errors++; $display("FAIL sat_reach got %0h want %0h", err_count, MAXE); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked got %0b want 1", locked); end
    drive(0, 1, lfsr_next(m_seed) ^ 8'hFF, 0);
    checks++; if (err_count !== 4'(MAXE)) begin errors++; $display("FAIL sat_hold got %0h want %0h", err_count, MAXE); end
    drive(0, 1, lfsr_next(m_seed), 0);
    drive(0, 1, lfsr_next(m_seed), 1);
    checks++; if (err_count !== '0) begin errors++; $display("FAIL clear got %0h want 0", err_count); end
    drive(0, 1, lfsr_next(m_seed) ^ 8'h01, 1);
    checks++; if (err_count !== 4'd1) begin errors++; $display("FAIL clear_with_err got %0h want 1", err_count); end
    drive(0, 1, lfsr_next(m_seed), 0);
  endtask

  task automatic test_valid_gap();
    bit [7:0] e0;
    logic [CNT_W-1:0] c0;
    drive(0, 1, lfsr_next(m_seed), 0);
    e0 = expected; c0 = err_count;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 8'($urandom), 0);
      checks++; if (locked !== 1'b1 || mismatch !== 1'b0 || expected !== e0 || err_count !== c0) begin
        errors++; $display("FAIL gap cycle %0d got l=%0b m=%0b e=%0h c=%0h want 1/0/%0h/%0h", i, locked, mismatch, expected, err_count, e0, c0);
      end
    end
    drive(0, 1, lfsr_next(m_seed), 0);
    checks++; if (locked !== 1'b1 || mismatch !== 1'b0) begin errors++; $display("FAIL gap_resume got l=%0b m=%0b want 1/0", locked, mismatch); end
  endtask

  task automatic test_reset_locked();
    drive(0, 1, lfsr_next(m_seed) ^ 8'h04, 0);
    drive(1, 1, lfsr_next(m_seed), 0);
    checks++; if (locked !== 1'b0 || err_count !== '0) begin errors++; $display("FAIL reset_locked got l=%0b c=%0h want 0/0", locked, err_count); end
    drive(0, 0, 8'h00, 0);
  endtask

  task automatic test_random();
    bit [7:0] d;
    int k;
    bit v, c;
    for (int n = 0; n < 2000; n++) begin
      v = ($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 31) == 0);
      k = $urandom_range(0, 99);
      if (k < 65) d = lfsr_next(m_seed);
      else if (k < 80) d = 8'($urandom);
      else if (k < 85) d = 8'h00;
      else d = lfsr_next(m_seed) ^ (8'h01 << $urandom_range(0, 7));
      drive(0, v, d, c);
      checks++;
      if (locked !== m_lock || mismatch !== m_mis || err_count !== 4'(m_err) || expected !== m_seed) begin
        errors++;
        $display("FAIL random cycle %0d got l=%0b m=%0b c=%0h e=%0h want %0b/%0b/%0h/%0h",
                 n, locked, mismatch, err_count, expected, m_lock, m_mis, m_err, m_seed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_single_error();
    test_loss_relock();
    test_zero_words();
    test_saturation();
    test_valid_gap();
    test_reset_locked();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
